// File: rtl/udp_tx_ddr_rd_ctrl.sv
// udp_tx_ddr_rd_ctrl: splits UDP TX frame commands into FDMA read bursts that fit in the
// TX buffer FIFO, and forwards the returned beats into the FIFO write port (clkw domain).
module udp_tx_ddr_rd_ctrl #(
    parameter int                ADDR_W     = 32,
    parameter int                LEN_W      = 16,
    parameter int                BURST_MAX  = 256,
    parameter int                FIFO_DEPTH = 2048,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                RING_WORDS = 1048576
) (
    input  logic              clkw,
    input  logic              wrst,
    input  logic              fifo_wr_rst_done,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [11:0]       fifo_wrusedw,
    output logic              fifo_we,
    output logic [31:0]       fifo_di,
    output logic              fdma_rareq,
    output logic [ADDR_W-1:0] fdma_raddr,
    output logic [8:0]        fdma_rsize,
    input  logic              fdma_rbusy,
    input  logic              fdma_rvalid,
    input  logic [31:0]       fdma_rdata,
    output logic              frame_done,
    output logic              busy,
    output logic              err_short
);

    // Beat counter saturates one above BURST_MAX so overlong bursts never wrap back to "equal".
    localparam int                BCNT_W   = $clog2(BURST_MAX + 2);
    localparam logic [BCNT_W-1:0] BCNT_SAT = BCNT_W'(BURST_MAX + 1);
    localparam logic [ADDR_W-1:0] RING_A   = ADDR_W'(RING_WORDS);
    localparam logic [ADDR_W-1:0] BURST_A  = ADDR_W'(BURST_MAX);
    localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SPACE,
        ST_REQ,
        ST_XFER,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_q, cur_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [1:0]          settle_q, settle_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic                rbusy_q, rbusy_d;
    logic                fifo_we_q, fifo_we_d;
    logic [31:0]         fifo_di_q, fifo_di_d;
    logic                err_q, err_d;

    logic [ADDR_W-1:0]   ring_left;
    logic [ADDR_W-1:0]   blen;
    logic [ADDR_W-1:0]   cur_sum;
    logic [ADDR_W:0]     fill_sum;
    logic                space_ok;
    logic [BCNT_W-1:0]   bcnt_next;

    // Burst length for the current position: limited by remaining words, burst cap and ring end.
    always_comb begin
        ring_left = RING_A - cur_q;
        blen      = ADDR_W'(rem_q);
        if (blen > BURST_A) begin
            blen = BURST_A;
        end
        if (blen > ring_left) begin
            blen = ring_left;
        end
        cur_sum  = cur_q + blen;
        fill_sum = (ADDR_W + 1)'(fifo_wrusedw) + (ADDR_W + 1)'(blen);
        space_ok = (fill_sum <= DEPTH_A);
    end

    // Next-state logic: command intake, space wait, burst request, beat forwarding and burst close.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        rem_d     = rem_q;
        settle_d  = settle_q;
        bcnt_d    = bcnt_q;
        rbusy_d   = fdma_rbusy;
        fifo_we_d = 1'b0;
        fifo_di_d = fifo_di_q;
        err_d     = err_q;
        bcnt_next = bcnt_q;
        case (state_q)
            ST_IDLE: begin
                settle_d = 2'd0;
                bcnt_d   = '0;
                if (cmd_valid && cmd_ready) begin
                    cur_d   = cmd_addr;
                    rem_d   = cmd_len;
                    state_d = (cmd_len == '0) ? ST_DONE : ST_WAIT_SPACE;
                end
            end
            ST_WAIT_SPACE: begin
                if (settle_q != 2'd2) begin
                    settle_d = settle_q + 2'd1;
                end else if (space_ok) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (fdma_rbusy) begin
                    bcnt_d  = '0;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (fdma_rvalid) begin
                    if (ADDR_W'(bcnt_q) < blen) begin
                        fifo_we_d = 1'b1;
                        fifo_di_d = fdma_rdata;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (bcnt_q != BCNT_SAT) begin
                        bcnt_next = bcnt_q + 1'b1;
                    end
                end
                bcnt_d = bcnt_next;
                if (rbusy_q && !fdma_rbusy) begin
                    if (ADDR_W'(bcnt_next) != blen) begin
                        err_d = 1'b1;
                    end
                    cur_d    = (cur_sum == RING_A) ? '0 : cur_sum;
                    rem_d    = rem_q - LEN_W'(blen);
                    settle_d = 2'd0;
                    bcnt_d   = '0;
                    state_d  = (ADDR_W'(rem_q) == blen) ? ST_DONE : ST_WAIT_SPACE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset that abandons any frame in progress.
    always_ff @(posedge clkw) begin
        if (wrst) begin
            state_q   <= ST_IDLE;
            cur_q     <= '0;
            rem_q     <= '0;
            settle_q  <= '0;
            bcnt_q    <= '0;
            rbusy_q   <= 1'b0;
            fifo_we_q <= 1'b0;
            fifo_di_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            rem_q     <= rem_d;
            settle_q  <= settle_d;
            bcnt_q    <= bcnt_d;
            rbusy_q   <= rbusy_d;
            fifo_we_q <= fifo_we_d;
            fifo_di_q <= fifo_di_d;
            err_q     <= err_d;
        end
    end

    // Output decode; request address and size are only driven while a request is pending.
    always_comb begin
        cmd_ready  = (state_q == ST_IDLE) && fifo_wr_rst_done && !wrst;
        fdma_rareq = (state_q == ST_REQ);
        fdma_raddr = (state_q == ST_REQ) ? (BASE_ADDR + (cur_q << 2)) : '0;
        fdma_rsize = (state_q == ST_REQ) ? 9'(blen) : 9'd0;
        frame_done = (state_q == ST_DONE);
        busy       = (state_q != ST_IDLE);
        fifo_we    = fifo_we_q;
        fifo_di    = fifo_di_q;
        err_short  = err_q;
    end

endmodule

// File: tb/tb_udp_tx_ddr_rd_ctrl.sv
// tb_udp_tx_ddr_rd_ctrl: randomized frames checked against a burst-splitting reference model,
// plus directed FIFO-space, short/long burst and mid-transfer reset scenarios.
module tb_udp_tx_ddr_rd_ctrl;

    localparam int          RING  = 1024;
    localparam int          BMAX  = 256;
    localparam int          DEPTH = 2048;
    localparam logic [31:0] BASE  = 32'h0001_0000;

    logic        clkw = 1'b0;
    logic        wrst;
    logic        fifo_wr_rst_done;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic [11:0] fifo_wrusedw;
    logic        fifo_we;
    logic [31:0] fifo_di;
    logic        fdma_rareq;
    logic [31:0] fdma_raddr;
    logic [8:0]  fdma_rsize;
    logic        fdma_rbusy;
    logic        fdma_rvalid;
    logic [31:0] fdma_rdata;
    logic        frame_done;
    logic        busy;
    logic        err_short;

    int          checks = 0;
    int          failures = 0;
    int          doneCount = 0;
    int          rareqCount = 0;
    int          errExp = 0;
    logic        prevRareq = 1'b0;
    logic [31:0] expQ[$];
    logic [31:0] gotQ[$];

    udp_tx_ddr_rd_ctrl #(
        .ADDR_W(32), .LEN_W(16), .BURST_MAX(BMAX), .FIFO_DEPTH(DEPTH),
        .BASE_ADDR(BASE), .RING_WORDS(RING)
    ) dut (
        .clkw(clkw), .wrst(wrst), .fifo_wr_rst_done(fifo_wr_rst_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .fifo_wrusedw(fifo_wrusedw), .fifo_we(fifo_we), .fifo_di(fifo_di),
        .fdma_rareq(fdma_rareq), .fdma_raddr(fdma_raddr), .fdma_rsize(fdma_rsize),
        .fdma_rbusy(fdma_rbusy), .fdma_rvalid(fdma_rvalid), .fdma_rdata(fdma_rdata),
        .frame_done(frame_done), .busy(busy), .err_short(err_short)
    );

    always #5 clkw = ~clkw;

    // Observe FIFO writes, frame completions and burst requests between clock edges.
    always @(negedge clkw) begin
        if (fifo_we) gotQ.push_back(fifo_di);
        if (frame_done) doneCount++;
        if (fdma_rareq && !prevRareq) rareqCount++;
        prevRareq = fdma_rareq;
    end

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clkw);
        #1;
    endtask

    task automatic applyStimulus(input int addr, input int len);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        checkOutput("cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len[15:0];
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic compareData();
        int mism = 0;
        int n;
        checkOutput("wr_count", gotQ.size(), expQ.size());
        n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            if (gotQ[i] != expQ[i]) mism++;
        end
        checkOutput("wr_data", mism, 0);
        gotQ.delete();
        expQ.delete();
    endtask

    // Responds to one burst request as the FDMA engine would, delivering nBeats beats.
    task automatic doBurst(input int expAddr, input int expSize, input int nBeats, output int waitCycles);
        int unstable = 0;
        int delay;
        waitCycles = 0;
        while (!fdma_rareq && waitCycles < 300) begin
            fdma_rvalid = ($urandom_range(0, 3) == 0);
            fdma_rdata  = $urandom;
            tick();
            waitCycles++;
        end
        fdma_rvalid = 1'b0;
        checkOutput("rareq_seen", fdma_rareq, 1);
        if (!fdma_rareq) return;
        checkOutput("raddr", fdma_raddr, expAddr);
        checkOutput("rsize", fdma_rsize, expSize);
        delay = $urandom_range(0, 3);
        repeat (delay) begin
            fdma_rvalid = $urandom_range(0, 1);
            fdma_rdata  = $urandom;
            tick();
            if (!fdma_rareq || fdma_raddr != expAddr || fdma_rsize != expSize) unstable++;
        end
        fdma_rvalid = 1'b0;
        checkOutput("req_stable", unstable, 0);
        fdma_rbusy = 1'b1;
        tick();
        checkOutput("rareq_drop", fdma_rareq, 0);
        for (int i = 0; i < nBeats; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            fdma_rvalid = 1'b1;
            fdma_rdata  = $urandom;
            if (i < expSize) expQ.push_back(fdma_rdata);
            tick();
            fdma_rvalid = 1'b0;
        end
        fdma_rbusy = 1'b0;
        tick();
    endtask

    task automatic endFrame(input int d0, input int r0, input int nBursts);
        int n = 0;
        while (!frame_done && n < 50) begin
            tick();
            n++;
        end
        checkOutput("frame_done", frame_done, 1);
        tick();
        checkOutput("done_pulse_len", frame_done, 0);
        checkOutput("ready_after_done", cmd_ready, 1);
        checkOutput("busy_idle", busy, 0);
        checkOutput("done_count", doneCount - d0, 1);
        checkOutput("burst_count", rareqCount - r0, nBursts);
        checkOutput("err_short", err_short, errExp);
        compareData();
    endtask

    // Reference model: the frame is cut at the burst cap and at the ring end, in order.
    task automatic runFrame(input int addr, input int len, input int shortIdx, input int shortBeats);
        int bAddr[$];
        int bSize[$];
        int cur = addr;
        int rem = len;
        int b;
        int nb;
        int w;
        int d0 = doneCount;
        int r0 = rareqCount;
        while (rem > 0) begin
            b = rem;
            if (b > BMAX) b = BMAX;
            if (b > RING - cur) b = RING - cur;
            bAddr.push_back(BASE + 4 * cur);
            bSize.push_back(b);
            cur = (cur + b) % RING;
            rem -= b;
        end
        applyStimulus(addr, len);
        for (int i = 0; i < bSize.size(); i++) begin
            nb = (i == shortIdx) ? shortBeats : bSize[i];
            if (nb != bSize[i]) errExp = 1;
            doBurst(bAddr[i], bSize[i], nb, w);
            if (i == 0) checkOutput("req_latency", w, 3);
        end
        endFrame(d0, r0, bSize.size());
    endtask

    task automatic doReset();
        wrst = 1'b1;
        tick();
        wrst = 1'b0;
        errExp = 0;
    endtask

    initial begin
        int d0;
        int r0;
        int hits;
        int w;
        wrst = 1'b1;
        fifo_wr_rst_done = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_len = '0;
        fifo_wrusedw = '0;
        fdma_rbusy = 1'b0;
        fdma_rvalid = 1'b0;
        fdma_rdata = '0;
        repeat (3) tick();
        checkOutput("rst_fifo_we", fifo_we, 0);
        checkOutput("rst_fifo_di", fifo_di, 0);
        checkOutput("rst_rareq", fdma_rareq, 0);
        checkOutput("rst_raddr", fdma_raddr, 0);
        checkOutput("rst_rsize", fdma_rsize, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err", err_short, 0);
        checkOutput("rst_cmd_ready", cmd_ready, 0);
        wrst = 1'b0;
        cmd_valid = 1'b1;
        cmd_len = 16'd5;
        repeat (3) tick();
        checkOutput("no_ready_before_fifo_rst", cmd_ready, 0);
        checkOutput("no_accept_before_fifo_rst", busy, 0);
        cmd_valid = 1'b0;
        fifo_wr_rst_done = 1'b1;
        tick();

        $display("[TB] T1/T2/T3 directed frames");
        runFrame(0, 100, -1, 0);
        runFrame(0, 600, -1, 0);
        runFrame(1000, 50, -1, 0);

        $display("[TB] randomized frames");
        for (int f = 0; f < 6; f++) begin
            fifo_wrusedw = 12'($urandom_range(0, DEPTH - BMAX));
            runFrame($urandom_range(0, RING - 1), $urandom_range(0, 600), -1, 0);
        end
        fifo_wrusedw = '0;

        $display("[TB] T4 FIFO space gating");
        d0 = doneCount;
        r0 = rareqCount;
        fifo_wrusedw = 12'd1900;
        applyStimulus(0, 256);
        hits = 0;
        repeat (20) begin
            if (fdma_rareq) hits++;
            tick();
        end
        fifo_wrusedw = 12'd1793;
        repeat (5) begin
            if (fdma_rareq) hits++;
            tick();
        end
        checkOutput("t4_no_req_when_full", hits, 0);
        checkOutput("t4_before_drop", fdma_rareq, 0);
        fifo_wrusedw = 12'd1792;
        tick();
        checkOutput("t4_req_after_space", fdma_rareq, 1);
        doBurst(BASE, 256, 256, w);
        fifo_wrusedw = '0;
        endFrame(d0, r0, 1);

        $display("[TB] T5 short and long bursts");
        runFrame(1008, 40, 0, 10);
        runFrame(0, 20, -1, 0);
        doReset();
        checkOutput("err_cleared_by_reset", err_short, 0);
        runFrame(1008, 16, 0, 18);

        $display("[TB] T6 reset during transfer");
        doReset();
        d0 = doneCount;
        applyStimulus(0, 256);
        w = 0;
        while (!fdma_rareq && w < 300) begin
            tick();
            w++;
        end
        checkOutput("t6_rareq_seen", fdma_rareq, 1);
        fdma_rbusy = 1'b1;
        tick();
        for (int i = 0; i < 40; i++) begin
            fdma_rvalid = 1'b1;
            fdma_rdata  = $urandom;
            expQ.push_back(fdma_rdata);
            tick();
        end
        wrst = 1'b1;
        fdma_rdata = $urandom;
        tick();
        wrst = 1'b0;
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_fifo_we", fifo_we, 0);
        checkOutput("t6_rareq", fdma_rareq, 0);
        checkOutput("t6_frame_done", frame_done, 0);
        for (int i = 0; i < 20; i++) begin
            fdma_rdata = $urandom;
            tick();
        end
        fdma_rvalid = 1'b0;
        fdma_rbusy = 1'b0;
        repeat (10) tick();
        compareData();
        checkOutput("t6_no_done", doneCount - d0, 0);
        checkOutput("t6_err", err_short, 0);
        runFrame(5, 0, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
